pi_nibble_bridge: RTL and testbench



---
 rtl/pi_nib_pkg.sv | 24 ++
 rtl/sync_edge.sv | 51 +++++
 rtl/pi_nibble_bridge.sv | 191 +++++++++++++++++++
 tb/tb_pi_nibble_bridge.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_nib_pkg.sv
// pi_nib_pkg
//   Shared types and constants for the Raspberry Pi nibble-bus bridge.
//   - state_t     : bridge FSM states
//   - CMD_DIR_BIT : command nibble bit selecting write (1) or read (0)
//   - CMD_IDX_MSB : top bit of the register index field in the command
//   - nibbles()   : number of 4-bit nibbles in a data word
package pi_nib_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WDATA,
      RLOAD,
      RDATA,
      DONE
   } state_t;

   localparam int CMD_DIR_BIT = 3;
   localparam int CMD_IDX_MSB = 2;

   function automatic int nibbles(input int data_w);
      return data_w / 4;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   Two-flop synchroniser for one asynchronous input, with an optional
//   rising-edge detector built from a third flop.
//   Ports:
//     clk   in  system clock
//     rst_n in  asynchronous active-low reset
//     d     in  asynchronous input
//     q     out synchronised level
//     rise  out one-cycle pulse on a synchronised 0->1 transition
//               (tied low when RISE_DET = 0)
module sync_edge #(
   parameter bit RISE_DET = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

   generate
      if (RISE_DET) begin : g_rise
         logic prev_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) prev_reg <= 1'b0;
            else        prev_reg <= sync_reg;
         end

         assign rise = sync_reg & ~prev_reg;
      end else begin : g_no_rise
         assign rise = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/pi_nibble_bridge.sv
// pi_nibble_bridge
//   Bridge between the Pi nibble bus and the card register file. The first
//   nibble after r_nibrst is a command (bit3 = write, bits2:0 = index);
//   data words then move MSB nibble first on each Pi clock rise.
//   Ports:
//     clk, rst_n          system clock, async active-low reset
//     r_clk, r_nibrst     Pi strobe and transfer reset (asynchronous)
//     r_nib_in            Pi nibble bus input
//     r_nib_out, r_nib_oe nibble presented to the Pi and its tristate enable
//     wr_strb/idx/data    one-cycle write pulse with held index and word
//     rd_idx, rd_data     register index being read and its host value
//     busy, err           FSM not idle; sticky out-of-range index flag
module pi_nibble_bridge
   import pi_nib_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r_clk,
   input  logic              r_nibrst,
   input  logic [3:0]        r_nib_in,
   output logic [3:0]        r_nib_out,
   output logic              r_nib_oe,
   output logic              wr_strb,
   output logic [2:0]        wr_idx,
   output logic [DATA_W-1:0] wr_data,
   output logic [2:0]        rd_idx,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              err
);

   localparam int NIBS  = nibbles(DATA_W);
   localparam int CNT_W = $clog2(NIBS) + 1;
   localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(NIBS - 1);
   // A single-nibble word never enters RDATA, so the value is irrelevant there.
   localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'((NIBS > 1) ? NIBS - 2 : 0);
   localparam logic [3:0]       NUM_REGS_L = 4'(NUM_REGS);

   // ---------------- synchronisers ----------------
   logic       clk_rise;
   logic       nibrst_sync;
   logic [3:0] nib_sync;
   logic       r_clk_level_unused;
   logic       nibrst_rise_unused;
   logic [3:0] nib_rise_unused;

   sync_edge #(.RISE_DET(1'b1)) u_sync_clk (
      .clk(clk), .rst_n(rst_n), .d(r_clk),
      .q(r_clk_level_unused), .rise(clk_rise)
   );

   sync_edge #(.RISE_DET(1'b0)) u_sync_nibrst (
      .clk(clk), .rst_n(rst_n), .d(r_nibrst),
      .q(nibrst_sync), .rise(nibrst_rise_unused)
   );

   // Same depth as the r_clk path, so the nibble is aligned with clk_rise.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_nib_sync
         sync_edge #(.RISE_DET(1'b0)) u_sync_nib (
            .clk(clk), .rst_n(rst_n), .d(r_nib_in[gi]),
            .q(nib_sync[gi]), .rise(nib_rise_unused[gi])
         );
      end
   endgenerate

   // ---------------- state ----------------
   state_t            state_reg,   state_next;
   logic [DATA_W-1:0] shift_reg,   shift_next;
   logic [CNT_W-1:0]  cnt_reg,     cnt_next;
   logic [2:0]        cmd_idx_reg, cmd_idx_next;
   logic              dir_wr_reg,  dir_wr_next;
   logic [2:0]        rd_idx_reg,  rd_idx_next;
   logic [2:0]        wr_idx_reg,  wr_idx_next;
   logic [DATA_W-1:0] wr_data_reg, wr_data_next;
   logic              wr_strb_reg, wr_strb_next;
   logic              err_reg,     err_next;

   logic [DATA_W-1:0] shift_in;
   logic              idx_bad;

   assign shift_in = (shift_reg << 4) | DATA_W'(nib_sync);
   assign idx_bad  = ({1'b0, cmd_idx_reg} >= NUM_REGS_L);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         cnt_reg     <= '0;
         cmd_idx_reg <= '0;
         dir_wr_reg  <= 1'b0;
         rd_idx_reg  <= '0;
         wr_idx_reg  <= '0;
         wr_data_reg <= '0;
         wr_strb_reg <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         cnt_reg     <= cnt_next;
         cmd_idx_reg <= cmd_idx_next;
         dir_wr_reg  <= dir_wr_next;
         rd_idx_reg  <= rd_idx_next;
         wr_idx_reg  <= wr_idx_next;
         wr_data_reg <= wr_data_next;
         wr_strb_reg <= wr_strb_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      cnt_next     = cnt_reg;
      cmd_idx_next = cmd_idx_reg;
      dir_wr_next  = dir_wr_reg;
      rd_idx_next  = rd_idx_reg;
      wr_idx_next  = wr_idx_reg;
      wr_data_next = wr_data_reg;
      wr_strb_next = 1'b0;
      err_next     = err_reg;

      // Transfer reset dominates: any clk_rise in the same cycle is dropped.
      if (nibrst_sync) begin
         state_next = IDLE;
         shift_next = '0;
         cnt_next   = '0;
         err_next   = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (clk_rise) begin
                  cmd_idx_next = nib_sync[CMD_IDX_MSB:0];
                  dir_wr_next  = nib_sync[CMD_DIR_BIT];
                  cnt_next     = '0;
                  if ({1'b0, nib_sync[CMD_IDX_MSB:0]} >= NUM_REGS_L) err_next = 1'b1;
                  if (nib_sync[CMD_DIR_BIT]) begin
                     state_next = WDATA;
                  end else begin
                     rd_idx_next = nib_sync[CMD_IDX_MSB:0];
                     state_next  = RLOAD;
                  end
               end
            end
            WDATA: begin
               if (clk_rise) begin
                  shift_next = shift_in;
                  cnt_next   = cnt_reg + 1'b1;
                  if (cnt_reg == WR_LAST) begin
                     state_next = DONE;
                     if (!idx_bad) begin
                        wr_strb_next = 1'b1;
                        wr_idx_next  = cmd_idx_reg;
                        wr_data_next = shift_in;
                     end
                  end
               end
            end
            RLOAD: begin
               shift_next = idx_bad ? '0 : rd_data;
               cnt_next   = '0;
               state_next = (NIBS == 1) ? DONE : RDATA;
            end
            RDATA: begin
               if (clk_rise) begin
                  shift_next = shift_reg << 4;
                  cnt_next   = cnt_reg + 1'b1;
                  if (cnt_reg == RD_LAST) state_next = DONE;
               end
            end
            DONE: begin
               // hold until r_nibrst
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign r_nib_out = shift_reg[DATA_W-1 -: 4];
   assign r_nib_oe  = (state_reg == RDATA) || ((state_reg == DONE) && !dir_wr_reg);
   assign wr_strb   = wr_strb_reg;
   assign wr_idx    = wr_idx_reg;
   assign wr_data   = wr_data_reg;
   assign rd_idx    = rd_idx_reg;
   assign busy      = (state_reg != IDLE);
   assign err       = err_reg;

endmodule

// File: tb/tb_pi_nibble_bridge.sv
// Bench for pi_nibble_bridge: unit 0 is DATA_W = 8, unit 1 is DATA_W = 16.
module tb_pi_nibble_bridge;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]      pclk = '0;
   logic [1:0]      prst = '0;
   logic [1:0][3:0] pnib = '0;

   logic [1:0][3:0] nout;
   logic [1:0]      oe, strb, busy, err;
   logic [1:0][2:0] widx, ridx;
   logic [7:0]      wdata8, rdata8;
   logic [15:0]     wdata16, rdata16;
   logic [7:0]      regs8  [8];
   logic [15:0]     regs16 [8];

   assign rdata8  = regs8[ridx[0]];
   assign rdata16 = regs16[ridx[1]];

   pi_nibble_bridge #(.DATA_W(8), .NUM_REGS(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .r_clk(pclk[0]), .r_nibrst(prst[0]),
      .r_nib_in(pnib[0]), .r_nib_out(nout[0]), .r_nib_oe(oe[0]),
      .wr_strb(strb[0]), .wr_idx(widx[0]), .wr_data(wdata8),
      .rd_idx(ridx[0]), .rd_data(rdata8), .busy(busy[0]), .err(err[0])
   );

   pi_nibble_bridge #(.DATA_W(16), .NUM_REGS(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .r_clk(pclk[1]), .r_nibrst(prst[1]),
      .r_nib_in(pnib[1]), .r_nib_out(nout[1]), .r_nib_oe(oe[1]),
      .wr_strb(strb[1]), .wr_idx(widx[1]), .wr_data(wdata16),
      .rd_idx(ridx[1]), .rd_data(rdata16), .busy(busy[1]), .err(err[1])
   );

   typedef struct {
      int          u;
      logic [2:0]  idx;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int         u;
      logic [3:0] nib;
   } rd_t;

   wr_t exp_wr[$];
   wr_t obs_wr[$];
   rd_t exp_rd[$];
   int  checks = 0;
   int  errors = 0;

   // Capture every write strobe; one entry per strobed cycle.
   always @(negedge clk) begin : mon
      wr_t w;
      if (strb[0]) begin
         w.u = 0; w.idx = widx[0]; w.data = 32'(wdata8);
         obs_wr.push_back(w);
      end
      if (strb[1]) begin
         w.u = 1; w.idx = widx[1]; w.data = 32'(wdata16);
         obs_wr.push_back(w);
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pi_up(input int u, input logic [3:0] nib);
      pnib[u] = nib;
      wait_clk(4);
      pclk[u] = 1'b1;
   endtask

   task automatic pi_nib(input int u, input logic [3:0] nib);
      pi_up(u, nib);
      wait_clk(5);
      pclk[u] = 1'b0;
      wait_clk(5);
   endtask

   task automatic pi_rst(input int u);
      prst[u] = 1'b1;
      wait_clk(5);
      prst[u] = 1'b0;
      wait_clk(5);
   endtask

   task automatic push_rd(input int u, input logic [3:0] nib);
      rd_t r;
      r.u = u; r.nib = nib;
      exp_rd.push_back(r);
   endtask

   task automatic test_reset();
      for (int u = 0; u < 2; u++) begin
         checks++;
         if (nout[u] !== 4'h0 || oe[u] !== 1'b0 || strb[u] !== 1'b0 || widx[u] !== 3'd0 ||
             ridx[u] !== 3'd0 || busy[u] !== 1'b0 || err[u] !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs u%0d got nib=%h oe=%b strb=%b widx=%0d ridx=%0d busy=%b err=%b want all 0",
                     u, nout[u], oe[u], strb[u], widx[u], ridx[u], busy[u], err[u]);
         end
      end
      checks++;
      if (wdata8 !== 8'h00 || wdata16 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_wdata got %h/%h want 0/0", wdata8, wdata16);
      end
   endtask

   task automatic test_write8();
      wr_t e, o;
      pi_rst(0);
      e.u = 0; e.idx = 3'd1; e.data = 32'h000000a5;
      exp_wr.push_back(e);
      pi_nib(0, 4'h9);
      pi_nib(0, 4'ha);
      // final nibble: strobe must appear exactly 1 cycle after clk_rise
      pi_up(0, 4'h5);
      wait_clk(2);
      checks++;
      if (strb[0] !== 1'b0) begin
         errors++; $display("FAIL w8_strobe_early got %b want 0", strb[0]);
      end
      wait_clk(1);
      checks++;
      if (strb[0] !== 1'b1) begin
         errors++; $display("FAIL w8_strobe_timing got %b want 1", strb[0]);
      end
      wait_clk(2);
      pclk[0] = 1'b0;
      wait_clk(5);
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin
         errors++; $display("FAIL w8_strobe_count got %0d want %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = obs_wr.pop_front();
         checks++;
         if (o.u !== e.u || o.idx !== e.idx || o.data !== e.data) begin
            errors++;
            $display("FAIL w8_word got u%0d idx=%0d data=%h want u%0d idx=%0d data=%h",
                     o.u, o.idx, o.data, e.u, e.idx, e.data);
         end
      end
      exp_wr.delete(); obs_wr.delete();
      pi_nib(0, 4'h3);   // ignored in DONE
      checks++;
      if (busy[0] !== 1'b1 || oe[0] !== 1'b0 || obs_wr.size() != 0) begin
         errors++;
         $display("FAIL w8_done got busy=%b oe=%b strobes=%0d want busy=1 oe=0 strobes=0",
                  busy[0], oe[0], obs_wr.size());
      end
      pi_rst(0);
      checks++;
      if (busy[0] !== 1'b0) begin
         errors++; $display("FAIL w8_busy_after_nibrst got %b want 0", busy[0]);
      end
   endtask

   task automatic test_read8();
      rd_t r;
      regs8[2] = 8'h5a;
      pi_rst(0);
      push_rd(0, 4'h5); push_rd(0, 4'ha); push_rd(0, 4'ha);
      pi_up(0, 4'h2);
      wait_clk(3);
      checks++;
      if (oe[0] !== 1'b0 || busy[0] !== 1'b1) begin
         errors++; $display("FAIL r8_rload got oe=%b busy=%b want oe=0 busy=1", oe[0], busy[0]);
      end
      wait_clk(1);
      r = exp_rd.pop_front();
      checks++;
      if (oe[0] !== 1'b1 || nout[0] !== r.nib) begin
         errors++; $display("FAIL r8_first got oe=%b nib=%h want oe=1 nib=%h", oe[0], nout[0], r.nib);
      end
      checks++;
      if (ridx[0] !== 3'd2) begin
         errors++; $display("FAIL r8_rd_idx got %0d want 2", ridx[0]);
      end
      wait_clk(1);
      pclk[0] = 1'b0;
      wait_clk(5);
      while (exp_rd.size() > 0) begin
         pi_nib(0, 4'h0);
         r = exp_rd.pop_front();
         checks++;
         if (oe[0] !== 1'b1 || nout[0] !== r.nib) begin
            errors++; $display("FAIL r8_nibble got oe=%b nib=%h want oe=1 nib=%h", oe[0], nout[0], r.nib);
         end
      end
      pi_rst(0);
      checks++;
      if (oe[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++; $display("FAIL r8_release got oe=%b busy=%b want 0/0", oe[0], busy[0]);
      end
   endtask

   task automatic test_wide16();
      wr_t e, o;
      rd_t r;
      pi_rst(1);
      e.u = 1; e.idx = 3'd0; e.data = 32'h00001234;
      exp_wr.push_back(e);
      pi_nib(1, 4'h8);
      pi_nib(1, 4'h1); pi_nib(1, 4'h2); pi_nib(1, 4'h3); pi_nib(1, 4'h4);
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin
         errors++; $display("FAIL w16_strobe_count got %0d want %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = obs_wr.pop_front();
         checks++;
         if (o.u !== e.u || o.idx !== e.idx || o.data !== e.data) begin
            errors++;
            $display("FAIL w16_word got u%0d idx=%0d data=%h want u%0d idx=%0d data=%h",
                     o.u, o.idx, o.data, e.u, e.idx, e.data);
         end
      end
      exp_wr.delete(); obs_wr.delete();
      regs16[3] = 16'hbeef;
      pi_rst(1);
      push_rd(1, 4'hb); push_rd(1, 4'he); push_rd(1, 4'he); push_rd(1, 4'hf); push_rd(1, 4'hf);
      pi_nib(1, 4'h3);
      while (exp_rd.size() > 0) begin
         r = exp_rd.pop_front();
         checks++;
         if (oe[1] !== 1'b1 || nout[1] !== r.nib) begin
            errors++; $display("FAIL r16_nibble got oe=%b nib=%h want oe=1 nib=%h", oe[1], nout[1], r.nib);
         end
         if (exp_rd.size() > 0) pi_nib(1, 4'h0);
      end
      pi_rst(1);
   endtask

   task automatic test_abort();
      pi_rst(0);
      pi_nib(0, 4'h9);
      pi_nib(0, 4'h7);
      pi_rst(0);
      checks++;
      if (obs_wr.size() != 0 || oe[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort got strobes=%0d oe=%b busy=%b want 0/0/0", obs_wr.size(), oe[0], busy[0]);
      end
      checks++;
      if (wdata8 !== 8'ha5 || widx[0] !== 3'd1) begin
         errors++; $display("FAIL abort_held got idx=%0d data=%h want idx=1 data=a5", widx[0], wdata8);
      end
      obs_wr.delete();
   endtask

   task automatic test_out_of_range();
      rd_t r;
      regs8[5] = 8'hff;
      pi_rst(0);
      pi_nib(0, 4'hd);
      pi_nib(0, 4'h1);
      pi_nib(0, 4'h2);
      checks++;
      if (obs_wr.size() != 0 || err[0] !== 1'b1 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL oor_write got strobes=%0d err=%b busy=%b want 0/1/1", obs_wr.size(), err[0], busy[0]);
      end
      obs_wr.delete();
      pi_rst(0);
      checks++;
      if (err[0] !== 1'b0) begin
         errors++; $display("FAIL oor_err_clear got %b want 0", err[0]);
      end
      push_rd(0, 4'h0); push_rd(0, 4'h0);
      pi_nib(0, 4'h5);
      while (exp_rd.size() > 0) begin
         r = exp_rd.pop_front();
         checks++;
         if (oe[0] !== 1'b1 || nout[0] !== r.nib || err[0] !== 1'b1) begin
            errors++;
            $display("FAIL oor_read got oe=%b nib=%h err=%b want oe=1 nib=%h err=1", oe[0], nout[0], err[0], r.nib);
         end
         if (exp_rd.size() > 0) pi_nib(0, 4'h0);
      end
      pi_rst(0);
      checks++;
      if (err[0] !== 1'b0) begin
         errors++; $display("FAIL oor_err_clear2 got %b want 0", err[0]);
      end
   endtask

   task automatic test_rst_mid_read();
      rd_t r;
      regs8[1] = 8'hc3;
      pi_rst(0);
      push_rd(0, 4'hc);
      pi_nib(0, 4'h1);
      r = exp_rd.pop_front();
      checks++;
      if (oe[0] !== 1'b1 || nout[0] !== r.nib) begin
         errors++; $display("FAIL rst_pre got oe=%b nib=%h want oe=1 nib=%h", oe[0], nout[0], r.nib);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (nout[0] !== 4'h0 || oe[0] !== 1'b0 || strb[0] !== 1'b0 || widx[0] !== 3'd0 || wdata8 !== 8'h00 ||
          ridx[0] !== 3'd0 || busy[0] !== 1'b0 || err[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got nib=%h oe=%b strb=%b widx=%0d wdata=%h ridx=%0d busy=%b err=%b want all 0",
                  nout[0], oe[0], strb[0], widx[0], wdata8, ridx[0], busy[0], err[0]);
      end
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(2);
      push_rd(0, 4'hc); push_rd(0, 4'h3);
      pi_nib(0, 4'h1);
      while (exp_rd.size() > 0) begin
         r = exp_rd.pop_front();
         checks++;
         if (oe[0] !== 1'b1 || nout[0] !== r.nib) begin
            errors++; $display("FAIL rst_after_read got oe=%b nib=%h want oe=1 nib=%h", oe[0], nout[0], r.nib);
         end
         if (exp_rd.size() > 0) pi_nib(0, 4'h0);
      end
      checks++;
      if (obs_wr.size() != 0) begin
         errors++; $display("FAIL rst_no_strobe got %0d strobes want 0", obs_wr.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         regs8[i]  = 8'(i * 17);
         regs16[i] = 16'(i * 4369);
      end
      rst_n = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(2);
      test_reset();
      test_write8();
      test_read8();
      test_wide16();
      test_abort();
      test_out_of_range();
      test_rst_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
